pc_fetch_unit: RTL

Instruction fetch stage of the multi-cycle RV32 core. Holds the architectural PC, issues one request per instruction to instruction memory over a valid/ready channel, captures the returned word, and presents it to decode with a valid/ready handshake. Sits directly downstream of the PC mux: the mux output `NextPC` arrives on `next_pc` and is committed to the PC when execute signals `pc_update`.

---
 rtl/cpu_pkg.sv | 16 +
 rtl/pc_fetch_unit.sv | 91 +++++++++
 2 files changed

// File: rtl/cpu_pkg.sv
// Shared core definitions: fetch FSM states, reset vector, NOP encoding.
package cpu_pkg;

  localparam int          XLEN             = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
  localparam logic [31:0] INST_NOP         = 32'h0000_0013; // addi x0, x0, 0

  typedef enum logic [2:0] {
    FS_REQ  = 3'd0,
    FS_WAIT = 3'd1,
    FS_HOLD = 3'd2,
    FS_EXEC = 3'd3,
    FS_HALT = 3'd4
  } fetch_state_e;

endpackage

// File: rtl/pc_fetch_unit.sv
// Instruction fetch stage: owns the architectural PC, fetches one word per
// instruction over a valid/ready channel and hands it to decode.
module pc_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] next_pc,
  input  logic        pc_update,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  output logic [31:0] pc,
  output logic        misaligned,
  output logic [31:0] fetch_count
);

  fetch_state_e    state;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] inst_q;
  logic [XLEN-1:0] inst_pc_q;
  logic            misaligned_q;
  logic [XLEN-1:0] fetch_cnt_q;

  // Handshake outputs are decoded from state only, so no input reaches an
  // output combinationally.
  assign imem_req_valid = (state == FS_REQ);
  assign imem_req_addr  = pc_q;
  assign inst_valid     = (state == FS_HOLD);
  assign inst           = inst_q;
  assign inst_pc        = inst_pc_q;
  assign pc             = pc_q;
  assign misaligned     = misaligned_q;
  assign fetch_count    = fetch_cnt_q;

  // Fetch FSM with PC, captured instruction, sticky fault flag and counter.
  // Responses outside WAIT (including late ones from before a reset, or a
  // same-cycle response in REQ) fall through the case and are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= FS_REQ;
      pc_q         <= RESET_PC;
      inst_q       <= INST_NOP;
      inst_pc_q    <= RESET_PC;
      misaligned_q <= 1'b0;
      fetch_cnt_q  <= '0;
    end else begin
      case (state)
        FS_REQ: begin
          if (imem_req_ready) state <= FS_WAIT;
        end
        FS_WAIT: begin
          if (imem_rsp_valid) begin
            inst_q    <= imem_rsp_data;
            inst_pc_q <= pc_q;
            state     <= FS_HOLD;
          end
        end
        FS_HOLD: begin
          if (inst_ready) begin
            fetch_cnt_q <= fetch_cnt_q + 32'd1;
            state       <= FS_EXEC;
          end
        end
        FS_EXEC: begin
          // PC only moves here, so the PC mux sees a constant Pc all instruction.
          if (pc_update) begin
            if (next_pc[1:0] == 2'b00) begin
              pc_q  <= next_pc;
              state <= FS_REQ;
            end else begin
              misaligned_q <= 1'b1;
              state        <= FS_HALT;
            end
          end
        end
        FS_HALT: state <= FS_HALT;
        default: state <= FS_HALT;
      endcase
    end
  end

endmodule
